ysyx_25020037_ifu: RTL and testbench
====================================

Name: ysyx_25020037_ifu

Overview:
Instruction fetch unit. It is the producing end of the 32-bit instruction word consumed by the decoder. It owns the PC, issues one read per instruction on a valid/ready instruction-memory bus, and presents the instruction word and its PC to the decoder with a valid/ready handshake. It then waits for the commit stage to return the next PC. Fetches are strictly one at a time: no prediction, no prefetch.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset.
TIMEOUT, 1024, maximum cycles in S_WAIT before a fault; 0 disables the timeout.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, synchronous, active-high.
ifu_req_valid  out  1  fetch request valid.
ifu_req_ready  in  1  memory accepts the request.
ifu_req_addr  out  32  fetch address; equals pc.
ifu_rsp_valid  in  1  response valid.
ifu_rsp_ready  out  1  IFU accepts the response.
ifu_rsp_data  in  32  instruction word.
ifu_rsp_err  in  1  bus error on this response.
inst_valid  out  1  inst/pc/inst_fault valid toward the decoder.
inst_ready  in  1  decoder takes the instruction.
inst  out  32  instruction word.
pc  out  32  PC of inst.
inst_fault  out  1  fetch fault; inst is forced to 32'h0000_0000.
next_pc_valid  in  1  commit returns the next PC.
next_pc  in  32  next PC (jump/branch target or pc+4).
fetch_cnt  out  CNT_W  count of instructions handed over; wraps.
stall_cnt  out  CNT_W  count of cycles spent in S_REQ or S_WAIT; wraps.

Behaviour:
- Reset state: state=S_REQ, pc=RESET_PC, inst=0, inst_fault=0, timeout counter=0, both performance counters=0.
- Reset outputs: ifu_req_valid=1 from the first cycle after reset; ifu_rsp_ready=0; inst_valid=0.
- Reset has priority over everything, in any state.
- States:
  - S_REQ: ifu_req_valid=1, ifu_req_addr=pc.
    - If pc[1:0]!=0 (misaligned): no request is issued; load inst=0 and inst_fault=1; go to S_OUT.
    - Else, when ifu_req_valid && ifu_req_ready: go to S_WAIT and clear the timeout counter.
    - ifu_req_addr stays stable while the request is stalled.
  - S_WAIT: ifu_rsp_ready=1.
    - On ifu_rsp_valid: inst=ifu_rsp_data and inst_fault=0, or inst=0 and inst_fault=1 if ifu_rsp_err; go to S_OUT.
    - Otherwise the timeout counter increments. When it reaches TIMEOUT (TIMEOUT!=0): inst=0, inst_fault=1, go to S_OUT. A response arriving in that same cycle takes priority over the timeout.
  - S_OUT: inst_valid=1; inst, pc and inst_fault are held stable.
    - On inst_ready: fetch_cnt increments, go to S_EXEC.
  - S_EXEC: all outputs idle.
    - On next_pc_valid: pc=next_pc, go to S_REQ.
- ifu_rsp_ready is 0 outside S_WAIT; responses presented then are ignored. Memory must not respond in the cycle its request is accepted.
- next_pc_valid is ignored outside S_EXEC. inst_ready is ignored outside S_OUT.
- Minimum latency per instruction is 4 cycles (S_REQ, S_WAIT, S_OUT, S_EXEC), with zero-wait memory and decoder/commit responding immediately.
- On a fault the PC is not advanced by the IFU; commit supplies the trap vector via next_pc.
- pc is 32 bits; no wrap handling beyond natural overflow.

Decomposition:
- Shared package (ysyx_25020037_pkg): state encoding (S_REQ, S_WAIT, S_OUT, S_EXEC, 2 bits), RESET_PC default, FAULT_INST=32'h0.
- One sub-module: ysyx_25020037_perf_cnt, a CNT_W-bit counter with an increment enable and synchronous reset. It is instantiated twice.

Test Plan:
1. Reset, then ifu_req_ready=1 with a 1-cycle response of data 0x00100093 -> req_addr=0x80000000. inst_valid rises exactly 2 cycles after the request handshake with inst=0x00100093, pc=0x80000000, fault=0. With inst_ready=1 and next_pc=0x80000004 returned -> the next req_addr is 0x80000004. fetch_cnt=1.
2. Back-pressure: ifu_req_ready low for 3 cycles, then inst_ready low for 5 cycles -> ifu_req_addr stable for 3 cycles and inst/pc stable for 5 cycles. stall_cnt increments during the 3 request-stall cycles and in S_WAIT, and not during the 5 cycles in S_OUT.
3. Misaligned: next_pc=0x80000002 -> no ifu_req_valid handshake occurs. Next cycle inst_valid=1, inst_fault=1, inst=0, pc=0x80000002.
4. Bus error and timeout: a response with ifu_rsp_err=1 -> inst_fault=1, inst=0. With TIMEOUT=8 and no response -> inst_fault=1 after 8 cycles in S_WAIT. With a response on the timeout cycle -> the data is taken and fault=0.
5. Spurious inputs: next_pc_valid pulsed in S_WAIT, and ifu_rsp_valid pulsed in S_EXEC -> no state or pc change.
6. Reset mid-operation: assert rst in S_WAIT and again in S_OUT -> the next cycle has state S_REQ, pc=RESET_PC, inst_valid=0, and both counters at 0.

Source files
------------

// File: rtl/ysyx_25020037_pkg.sv
// Shared types and constants for the ysyx_25020037 instruction fetch unit.
`timescale 1ns/1ps
package ysyx_25020037_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2,
    S_EXEC = 2'd3
  } ifu_state_e;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [XLEN-1:0] FAULT_INST   = 32'h0000_0000;

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_25020037_perf_cnt.sv
// Free-running wrapping event counter with synchronous reset.
`timescale 1ns/1ps
module ysyx_25020037_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ysyx_25020037_ifu.sv
// Instruction fetch unit: one outstanding fetch at a time, handed to the decoder,
// then waits for commit to return the next PC.
`timescale 1ns/1ps
module ysyx_25020037_ifu
  import ysyx_25020037_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned     TIMEOUT  = 1024,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  output logic [XLEN-1:0]  ifu_req_addr,
  input  logic             ifu_rsp_valid,
  output logic             ifu_rsp_ready,
  input  logic [XLEN-1:0]  ifu_rsp_data,
  input  logic             ifu_rsp_err,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [XLEN-1:0]  inst,
  output logic [XLEN-1:0]  pc,
  output logic             inst_fault,
  input  logic             next_pc_valid,
  input  logic [XLEN-1:0]  next_pc,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned TMO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  ifu_state_e       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  inst_q, inst_d;
  logic             fault_q, fault_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             req_valid_q, req_valid_d;
  logic             rsp_ready_q, rsp_ready_d;
  logic             inst_valid_q, inst_valid_d;
  logic             fetch_en;
  logic             stall_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= FAULT_INST;
      fault_q      <= 1'b0;
      tmo_q        <= '0;
      req_valid_q  <= is_aligned(RESET_PC);
      rsp_ready_q  <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      fault_q      <= fault_d;
      tmo_q        <= tmo_d;
      req_valid_q  <= req_valid_d;
      rsp_ready_q  <= rsp_ready_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // Handshake outputs are registered from the next state so they line up with state_q.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    tmo_d   = tmo_q;

    case (state_q)
      S_REQ: begin
        if (!is_aligned(pc_q)) begin
          inst_d  = FAULT_INST;
          fault_d = 1'b1;
          state_d = S_OUT;
        end else if (req_valid_q && ifu_req_ready) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ifu_rsp_valid) begin
          inst_d  = ifu_rsp_err ? FAULT_INST : ifu_rsp_data;
          fault_d = ifu_rsp_err;
          state_d = S_OUT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if ((TIMEOUT != 0) && (tmo_q == TMO_W'(TMO_LAST))) begin
            inst_d  = FAULT_INST;
            fault_d = 1'b1;
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (inst_ready) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (next_pc_valid) begin
          pc_d    = next_pc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    req_valid_d  = (state_d == S_REQ) && is_aligned(pc_d);
    rsp_ready_d  = (state_d == S_WAIT);
    inst_valid_d = (state_d == S_OUT);
  end

  assign fetch_en = (state_q == S_OUT) && inst_ready;
  assign stall_en = (state_q == S_REQ) || (state_q == S_WAIT);

  ysyx_25020037_perf_cnt #(.CNT_W(CNT_W)) u_fetch_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (fetch_en),
    .cnt_o (fetch_cnt)
  );

  ysyx_25020037_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (stall_en),
    .cnt_o (stall_cnt)
  );

  assign ifu_req_valid = req_valid_q;
  assign ifu_req_addr  = pc_q;
  assign ifu_rsp_ready = rsp_ready_q;
  assign inst_valid    = inst_valid_q;
  assign inst          = inst_q;
  assign pc            = pc_q;
  assign inst_fault    = fault_q;

endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// Scoreboard bench for ysyx_25020037_ifu: expected instructions are queued as the
// memory model responds and popped on each decoder handshake.
`timescale 1ns/1ps
module tb_ysyx_25020037_ifu;

  localparam int          TMO      = 8;
  localparam logic [31:0] RST_PC   = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic [31:0] ifu_rsp_data;
  logic        ifu_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_fault;
  logic        next_pc_valid;
  logic [31:0] next_pc;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   exp_fetch;
  int   exp_stall;

  ysyx_25020037_ifu #(
    .RESET_PC (RST_PC),
    .TIMEOUT  (TMO),
    .CNT_W    (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rsp_data  (ifu_rsp_data),
    .ifu_rsp_err   (ifu_rsp_err),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .pc            (pc),
    .inst_fault    (inst_fault),
    .next_pc_valid (next_pc_valid),
    .next_pc       (next_pc),
    .fetch_cnt     (fetch_cnt),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decoder-side monitor: the handshake completes on the coming rising edge.
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_inst", inst, e.inst);
        chk("sb_pc", pc, e.pc);
        chk("sb_fault", 32'(inst_fault), 32'(e.fault));
      end
    end
  end

  task automatic do_reset();
    rst           = 1'b1;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
    inst_ready    = 1'b0;
    next_pc_valid = 1'b0;
    step();
    chk("rst_req_valid", 32'(ifu_req_valid), 32'd1);
    chk("rst_rsp_ready", 32'(ifu_rsp_ready), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_req_addr", ifu_req_addr, RST_PC);
    chk("rst_inst", inst, 32'h0);
    chk("rst_fault", 32'(inst_fault), 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    rst       = 1'b0;
    exp_fetch = 0;
    exp_stall = 0;
    sb.delete();
  endtask

  // mode: 0 data, 1 bus error, 2 timeout, 3 response on the timeout cycle.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int mode,
                       input int req_stall, input int rsp_delay, input int out_stall,
                       input bit spur, input logic [31:0] npc);
    logic [31:0] e_inst;
    logic        e_fault;
    int          ws;
    e_fault = (addr[1:0] != 2'b00) || (mode == 1) || (mode == 2);
    e_inst  = e_fault ? 32'h0 : data;
    chk("req_addr", ifu_req_addr, addr);
    chk("pc_req", pc, addr);
    if (addr[1:0] != 2'b00) begin
      chk("req_valid_mis", 32'(ifu_req_valid), 32'd0);
      ifu_req_ready = 1'b1;
      sb.push_back('{e_inst, addr, e_fault});
      step();
      ifu_req_ready = 1'b0;
      exp_stall += 1;
    end else begin
      chk("req_valid", 32'(ifu_req_valid), 32'd1);
      for (int i = 0; i < req_stall; i++) begin
        step();
        chk("req_addr_hold", ifu_req_addr, addr);
        chk("req_valid_hold", 32'(ifu_req_valid), 32'd1);
      end
      ifu_req_ready = 1'b1;
      step();
      ifu_req_ready = 1'b0;
      chk("rsp_ready", 32'(ifu_rsp_ready), 32'd1);
      chk("ival_wait", 32'(inst_valid), 32'd0);
      if (spur) begin
        next_pc_valid = 1'b1;
        next_pc       = 32'h0bad_f00c;
      end
      ws = (mode >= 2) ? TMO - 1 : rsp_delay;
      for (int i = 0; i < ws; i++) begin
        step();
        next_pc_valid = 1'b0;
        chk("ival_wait_hold", 32'(inst_valid), 32'd0);
        chk("rsp_ready_hold", 32'(ifu_rsp_ready), 32'd1);
      end
      if (mode == 2) begin
        sb.push_back('{e_inst, addr, e_fault});
        step();
      end else begin
        ifu_rsp_valid = 1'b1;
        ifu_rsp_data  = data;
        ifu_rsp_err   = (mode == 1);
        sb.push_back('{e_inst, addr, e_fault});
        step();
        ifu_rsp_valid = 1'b0;
        ifu_rsp_err   = 1'b0;
        ifu_rsp_data  = 32'h0;
      end
      next_pc_valid = 1'b0;
      exp_stall += req_stall + 1 + ws + 1;
    end
    chk("inst_valid", 32'(inst_valid), 32'd1);
    chk("inst", inst, e_inst);
    chk("fault", 32'(inst_fault), 32'(e_fault));
    chk("pc_out", pc, addr);
    chk("rsp_ready_out", 32'(ifu_rsp_ready), 32'd0);
    chk("req_valid_out", 32'(ifu_req_valid), 32'd0);
    chk("stall_out", stall_cnt, 32'(exp_stall));
    for (int i = 0; i < out_stall; i++) begin
      step();
      chk("ival_hold", 32'(inst_valid), 32'd1);
      chk("inst_hold", inst, e_inst);
      chk("pc_hold", pc, addr);
      chk("stall_hold", stall_cnt, 32'(exp_stall));
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    exp_fetch++;
    chk("ival_exec", 32'(inst_valid), 32'd0);
    chk("req_valid_exec", 32'(ifu_req_valid), 32'd0);
    chk("fetch_cnt", fetch_cnt, 32'(exp_fetch));
    if (spur) begin
      ifu_rsp_valid = 1'b1;
      ifu_rsp_data  = 32'hffff_ffff;
      ifu_rsp_err   = 1'b1;
      step();
      ifu_rsp_valid = 1'b0;
      ifu_rsp_err   = 1'b0;
      chk("inst_exec_hold", inst, e_inst);
      chk("fault_exec_hold", 32'(inst_fault), 32'(e_fault));
      chk("pc_exec_hold", pc, addr);
      chk("ival_exec_hold", 32'(inst_valid), 32'd0);
      chk("req_valid_exec_hold", 32'(ifu_req_valid), 32'd0);
    end
    next_pc_valid = 1'b1;
    next_pc       = npc;
    step();
    next_pc_valid = 1'b0;
    chk("stall_cnt", stall_cnt, 32'(exp_stall));
    chk("fetch_cnt_req", fetch_cnt, 32'(exp_fetch));
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] npc;
    logic [31:0] r;
    int          m;
    checks        = 0;
    errors        = 0;
    exp_fetch     = 0;
    exp_stall     = 0;
    rst           = 1'b1;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_data  = 32'h0;
    ifu_rsp_err   = 1'b0;
    inst_ready    = 1'b0;
    next_pc_valid = 1'b0;
    next_pc       = 32'h0;
    do_reset();

    fetch(32'h8000_0000, 32'h0010_0093, 0, 0, 0, 0, 1'b0, 32'h8000_0004);
    fetch(32'h8000_0004, 32'h0020_8113, 0, 3, 2, 5, 1'b1, 32'h8000_0002);
    fetch(32'h8000_0002, 32'h0,         0, 0, 0, 1, 1'b0, 32'h8000_0100);
    fetch(32'h8000_0100, 32'h1234_5678, 1, 1, 0, 0, 1'b0, 32'h8000_0104);
    fetch(32'h8000_0104, 32'h0,         2, 0, 0, 0, 1'b1, 32'h8000_0108);
    fetch(32'h8000_0108, 32'hcafe_0013, 3, 0, 0, 2, 1'b0, 32'h8000_010c);

    a = 32'h8000_010c;
    for (int k = 0; k < 6; k++) begin
      r   = $urandom;
      npc = (k % 2 == 0) ? a + 32'd4 : {r[31:2], 2'b00};
      m   = $urandom_range(0, 1);
      fetch(a, $urandom, m, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)), npc);
      a = npc;
    end

    // Reset while waiting on memory.
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    chk("mid_wait_rsp_ready", 32'(ifu_rsp_ready), 32'd1);
    do_reset();
    fetch(RST_PC, 32'h0000_0013, 0, 0, 1, 0, 1'b0, 32'h8000_0040);

    // Reset while presenting to the decoder.
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h0040_0513;
    step();
    ifu_rsp_valid = 1'b0;
    chk("mid_out_ival", 32'(inst_valid), 32'd1);
    chk("mid_out_inst", inst, 32'h0040_0513);
    do_reset();
    fetch(RST_PC, 32'h0050_0593, 0, 0, 0, 0, 1'b0, 32'h8000_0004);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
